replicator_stim_sequencer: RTL

Sequential stimulus-and-capture stage that sits directly upstream of the `Replicator` combinational block. It drives `Replicator` inputs `a`, `b`, `c` and `d` through all 16 input codes in ascending order, holding each code for a programmable dwell. At the end of each dwell it samples the returned `out1`/`out2`/`out3` into a 16-entry result store, so the truth table can be read back on hardware without a simulator.

---
 rtl/replicator_stim_sequencer_pkg.sv | 23 ++
 rtl/replicator_stim_sequencer_store.sv | 31 +++
 rtl/replicator_stim_sequencer.sv | 129 ++++++++++++
 3 files changed

// File: rtl/replicator_stim_sequencer_pkg.sv
// Shared encodings and sizes for the Replicator stimulus sequencer and its result store.
// The state values are fixed 3-bit codes so they stay stable in waveforms and debug reads.
package replicator_stim_sequencer_pkg;

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_DRIVE     = 3'd1;
    localparam logic [2:0] ST_SAMPLE    = 3'd2;
    localparam logic [2:0] ST_WAIT_STEP = 3'd3;
    localparam logic [2:0] ST_DONE      = 3'd4;

    localparam int VEC_COUNT = 16;
    localparam int RES_W     = 3;
    localparam int IDX_W     = $clog2(VEC_COUNT);

    typedef enum logic [2:0] {
        IDLE      = ST_IDLE,
        DRIVE     = ST_DRIVE,
        SAMPLE    = ST_SAMPLE,
        WAIT_STEP = ST_WAIT_STEP,
        DONE      = ST_DONE
    } state_t;

endpackage

// File: rtl/replicator_stim_sequencer_store.sv
// 16x3 result register file: one write port, one registered read port, synchronous clear.
// Reads return the pre-write contents when both ports hit the same address in one cycle.
module result_store16x3
    import replicator_stim_sequencer_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [IDX_W-1:0] waddr,
    input  logic [RES_W-1:0] wdata,
    input  logic [IDX_W-1:0] raddr,
    output logic [RES_W-1:0] rdata
);

    logic [RES_W-1:0] mem [VEC_COUNT];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < VEC_COUNT; i++) begin
                mem[i] <= '0;
            end
            rdata <= '0;
        end else begin
            if (we) begin
                mem[waddr] <= wdata;
            end
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/replicator_stim_sequencer.sv
// Sweeps the Replicator inputs through all 16 codes, holding each for DWELL+1 cycles,
// and captures {out1,out2,out3} per code into a readable result store.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | after reset, waiting for start
// DRIVE     | current code held on a..d while the dwell counter runs
// SAMPLE    | one cycle: capture outputs, choose next code / pause / finish
// WAIT_STEP | step mode pause after a capture, code held until step
// DONE      | sweep complete, last code held, start begins a new sweep
module replicator_stim_sequencer
    import replicator_stim_sequencer_pkg::*;
#(
    parameter int DWELL   = 50,
    parameter int DWELL_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             step_mode,
    input  logic             step,
    input  logic             out1,
    input  logic             out2,
    input  logic             out3,
    output logic             a,
    output logic             b,
    output logic             c,
    output logic             d,
    output logic [IDX_W-1:0] vec_idx,
    output logic             busy,
    output logic             done,
    output logic             sample_valid,
    input  logic [IDX_W-1:0] rd_addr,
    output logic [RES_W-1:0] rd_data
);

    localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(DWELL - 1);
    localparam logic [IDX_W-1:0]   IDX_LAST   = IDX_W'(VEC_COUNT - 1);

    state_t             state_q, state_d;
    logic [DWELL_W-1:0] cnt_q, cnt_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               pause_q, pause_d;
    logic               sv_q, sv_d;
    logic               store_we;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            pause_q <= 1'b0;
            sv_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            pause_q <= pause_d;
            sv_q    <= sv_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        pause_d  = pause_q;
        sv_d     = 1'b0;
        store_we = 1'b0;
        unique case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = DRIVE;
                    idx_d   = '0;
                    cnt_d   = '0;
                end
            end
            DRIVE: begin
                if (cnt_q == DWELL_LAST) begin
                    state_d = SAMPLE;
                    // step_mode is latched here so a change during SAMPLE cannot split the decision
                    pause_d = step_mode;
                end else begin
                    cnt_d = cnt_q + DWELL_W'(1);
                end
            end
            SAMPLE: begin
                store_we = 1'b1;
                sv_d     = 1'b1;
                if (idx_q == IDX_LAST) begin
                    state_d = DONE;
                end else if (pause_q) begin
                    state_d = WAIT_STEP;
                end else begin
                    state_d = DRIVE;
                    idx_d   = idx_q + IDX_W'(1);
                    cnt_d   = '0;
                end
            end
            WAIT_STEP: begin
                if (step) begin
                    state_d = DRIVE;
                    idx_d   = idx_q + IDX_W'(1);
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign {a, b, c, d}  = idx_q;
    assign vec_idx       = idx_q;
    assign busy          = (state_q == DRIVE) || (state_q == SAMPLE) || (state_q == WAIT_STEP);
    assign done          = (state_q == DONE);
    assign sample_valid  = sv_q;

    result_store16x3 u_store (
        .clk   (clk),
        .rst   (rst),
        .we    (store_we),
        .waddr (idx_q),
        .wdata ({out1, out2, out3}),
        .raddr (rd_addr),
        .rdata (rd_data)
    );

endmodule
